sdcard_clk_gen_v2: RTL and testbench

//  Parametrised successor SD-card clock generator for the APB-side controller core.
//  - Divides PCLK_i into sd_clk_o; f_sd = f_PCLK / (2*(div+1)).
//  - Divider changes are glitch-free: a new divider is applied only at a falling edge.
//  - Stop-clock request/ack handshake (for card flow control) that never truncates a high phase.
//  - One-cycle edge strobes for the CMD/DAT samplers.
//  - Built-in frequency meter that replaces the old calibration search.

---
 rtl/sdcard_clk_pkg.sv | 16 +
 rtl/sdcard_clk_edge_meter.sv | 68 ++++++
 rtl/sdcard_clk_gen_v2.sv | 154 +++++++++++++++
 tb/tb_sdcard_clk_gen_v2.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_clk_pkg.sv
// Shared types and defaults for the SD-card clock generator.
// State encoding plus the reset divider and widths.
package sdcard_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    PDOWN = 2'd3
  } sdclk_state_t;

  localparam int DIV_W_DEF    = 16;
  localparam int INIT_DIV_DEF = 124;
  localparam int MEAS_W_DEF   = 16;

endpackage

// File: rtl/sdcard_clk_edge_meter.sv
// Frequency meter: counts SD clock rise strobes over a PCLK window.
// Count saturates; an abort drops busy without a done pulse.
module sdcard_clk_edge_meter
  import sdcard_clk_pkg::*;
#(
  parameter int MEAS_W = MEAS_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rise_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [MEAS_W-1:0] window_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [MEAS_W-1:0] count_o
);

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [MEAS_W-1:0] rem_q, rem_d;
  logic [MEAS_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
    end
  end

  // rem_q holds the cycles still to be sampled, including this one
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (rise_i && cnt_q != '1)
        cnt_d = cnt_q + MEAS_W'(1);
      rem_d = rem_q - MEAS_W'(1);
      if (rem_q == MEAS_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      cnt_d = '0;
      rem_d = window_i;
      if (window_i == '0)
        done_d = 1'b1;
      else
        busy_d = 1'b1;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/sdcard_clk_gen_v2.sv
// SD-card clock divider with glitch-free reload, stop handshake,
// edge strobes and a built-in frequency meter.
module sdcard_clk_gen_v2
  import sdcard_clk_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int INIT_DIV = INIT_DIV_DEF,
  parameter int MEAS_W   = MEAS_W_DEF
) (
  input  logic              PCLK_i,
  input  logic              PRESETn_i,
  input  logic              clk_en_i,
  input  logic              power_down_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              div_load_i,
  output logic              div_busy_o,
  output logic [DIV_W-1:0]  active_div_o,
  input  logic              stop_req_i,
  output logic              stop_ack_o,
  output logic              sd_clk_o,
  output logic              sd_clk_rise_o,
  output logic              sd_clk_fall_o,
  input  logic              meas_start_i,
  input  logic [MEAS_W-1:0] meas_window_i,
  output logic              meas_busy_o,
  output logic              meas_done_o,
  output logic [MEAS_W-1:0] meas_count_o
);

  sdclk_state_t     state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             at_end;
  logic             fall_tgl;
  logic             apply;

  assign at_end   = (cnt_q == act_q);
  assign fall_tgl = (state_q == RUN) && clk_q && at_end;

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= DIV_W'(INIT_DIV);
      pend_q  <= DIV_W'(INIT_DIV);
      busy_q  <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    if (power_down_i) begin
      state_d = PDOWN;
      cnt_d   = '0;
      clk_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          clk_d = 1'b0;
          cnt_d = '0;
          if (clk_en_i)
            state_d = RUN;
        end
        RUN: begin
          if (at_end) begin
            clk_d = !clk_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // a high phase always runs to its falling toggle
          if (!clk_en_i || stop_req_i) begin
            if (!clk_q || at_end) begin
              state_d = clk_en_i ? HOLD : IDLE;
              clk_d   = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        HOLD: begin
          clk_d = 1'b0;
          cnt_d = '0;
          if (!clk_en_i)
            state_d = IDLE;
          else if (!stop_req_i)
            state_d = RUN;
        end
        PDOWN: begin
          clk_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
    rise_d = clk_d && !clk_q;
    fall_d = !clk_d && clk_q && !power_down_i;
  end

  // a load landing on the apply cycle stays pending
  always_comb begin
    apply  = busy_q && ((state_q != RUN) || fall_tgl);
    act_d  = apply ? pend_q : act_q;
    pend_d = div_load_i ? div_i : pend_q;
    busy_d = div_load_i || (busy_q && !apply);
  end

  always_comb begin
    stop_ack_o    = (state_q == HOLD);
    sd_clk_o      = clk_q;
    sd_clk_rise_o = rise_q;
    sd_clk_fall_o = fall_q;
    div_busy_o    = busy_q;
    active_div_o  = act_q;
  end

  sdcard_clk_edge_meter #(
    .MEAS_W (MEAS_W)
  ) u_meter (
    .clk_i    (PCLK_i),
    .rst_ni   (PRESETn_i),
    .rise_i   (rise_q),
    .start_i  (meas_start_i),
    .abort_i  (power_down_i),
    .window_i (meas_window_i),
    .busy_o   (meas_busy_o),
    .done_o   (meas_done_o),
    .count_o  (meas_count_o)
  );

endmodule

// File: tb/tb_sdcard_clk_gen_v2.sv
// Directed bench for sdcard_clk_gen_v2.
// Expected values are hand-derived cycle counts.
module tb_sdcard_clk_gen_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        pd = 1'b0;
  logic [15:0] div_in = '0;
  logic        div_load = 1'b0;
  logic        div_busy;
  logic [15:0] act_div;
  logic        stop_req = 1'b0;
  logic        stop_ack;
  logic        sd_clk;
  logic        rise;
  logic        fall;
  logic        m_start = 1'b0;
  logic [15:0] m_win = '0;
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_cnt;

  int nchk = 0;
  int nerr = 0;
  int n;
  int seen;

  always #5 clk = ~clk;

  sdcard_clk_gen_v2 dut (
    .PCLK_i        (clk),
    .PRESETn_i     (rst_n),
    .clk_en_i      (clk_en),
    .power_down_i  (pd),
    .div_i         (div_in),
    .div_load_i    (div_load),
    .div_busy_o    (div_busy),
    .active_div_o  (act_div),
    .stop_req_i    (stop_req),
    .stop_ack_o    (stop_ack),
    .sd_clk_o      (sd_clk),
    .sd_clk_rise_o (rise),
    .sd_clk_fall_o (fall),
    .meas_start_i  (m_start),
    .meas_window_i (m_win),
    .meas_busy_o   (m_busy),
    .meas_done_o   (m_done),
    .meas_count_o  (m_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_sd(input logic v, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sd_clk !== v && cnt < 400);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sd"}, sd_clk, 0);
    chk({tag, "_rise"}, rise, 0);
    chk({tag, "_fall"}, fall, 0);
    chk({tag, "_ack"}, stop_ack, 0);
    chk({tag, "_dbusy"}, div_busy, 0);
    chk({tag, "_adiv"}, act_div, 124);
    chk({tag, "_mbusy"}, m_busy, 0);
    chk({tag, "_mdone"}, m_done, 0);
    chk({tag, "_mcnt"}, m_cnt, 0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_sd", sd_clk, 0);

    // 1: default divider, 125-cycle phases
    clk_en = 1'b1;
    tick();
    wait_sd(1'b1, n);
    chk("t1_first_rise", n, 125);
    chk("t1_rise_stb", rise, 1);
    chk("t1_fall_stb0", fall, 0);
    wait_sd(1'b0, n);
    chk("t1_high", n, 125);
    chk("t1_fall_stb", fall, 1);
    chk("t1_rise_stb0", rise, 0);
    wait_sd(1'b1, n);
    chk("t1_low", n, 125);
    tick();
    chk("t1_rise_1cyc", rise, 0);
    clk_en = 1'b0;
    wait_sd(1'b0, n);
    chk("t1_exit_high", n, 124);
    chk("t1_exit_fall", fall, 1);
    tick();
    chk("t1_idle_fall0", fall, 0);

    // 2: load in IDLE, then reload mid-high
    div_in = 16'd3;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("t2_busy_idle", div_busy, 1);
    chk("t2_adiv_old", act_div, 124);
    tick();
    chk("t2_busy_clr", div_busy, 0);
    chk("t2_adiv3", act_div, 3);
    clk_en = 1'b1;
    tick();
    wait_sd(1'b1, n);
    chk("t2_rise4", n, 4);
    tick();
    tick();
    div_in = 16'd0;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("t2_hi_cnt3", sd_clk, 1);
    chk("t2_busy_hi", div_busy, 1);
    chk("t2_adiv_hold", act_div, 3);
    tick();
    chk("t2_fall_sd", sd_clk, 0);
    chk("t2_fall_stb", fall, 1);
    chk("t2_busy_fall", div_busy, 0);
    chk("t2_adiv0", act_div, 0);
    tick();
    chk("t2_d0_hi", sd_clk, 1);
    chk("t2_d0_rise", rise, 1);
    tick();
    chk("t2_d0_lo", sd_clk, 0);
    chk("t2_d0_fall", fall, 1);

    // 3: stop request mid-high
    div_in = 16'd3;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (div_busy && n < 20);
    chk("t3_busy_n", n, 1);
    chk("t3_adiv3", act_div, 3);
    wait_sd(1'b1, n);
    chk("t3_rise4", n, 4);
    stop_req = 1'b1;
    tick();
    chk("t3_hi1", sd_clk, 1);
    chk("t3_ack_hi1", stop_ack, 0);
    tick();
    tick();
    chk("t3_hi3", sd_clk, 1);
    chk("t3_ack_hi3", stop_ack, 0);
    tick();
    chk("t3_fall_sd", sd_clk, 0);
    chk("t3_fall_stb", fall, 1);
    chk("t3_ack", stop_ack, 1);
    tick();
    chk("t3_ack_hold", stop_ack, 1);
    chk("t3_hold_fall0", fall, 0);
    stop_req = 1'b0;
    tick();
    chk("t3_ack_drop", stop_ack, 0);
    chk("t3_run_sd", sd_clk, 0);
    wait_sd(1'b1, n);
    chk("t3_rel_rise4", n, 4);

    // 4: meter at div=4 over 1000 cycles
    div_in = 16'd4;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (div_busy && n < 20);
    chk("t4_adiv4", act_div, 4);
    m_win = 16'd1000;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    chk("t4_mbusy", m_busy, 1);
    n = 1;
    m_win = 16'd5;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    n++;
    while (!m_done && n < 1100) begin
      tick();
      n++;
    end
    chk("t4_done_at", n, 1001);
    chk("t4_cnt_range",
        ((m_cnt >= 99) && (m_cnt <= 101)), 1);
    chk("t4_mbusy_clr", m_busy, 0);
    tick();
    chk("t4_done_1cyc", m_done, 0);
    m_win = 16'd0;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    chk("t4_w0_done", m_done, 1);
    chk("t4_w0_cnt", m_cnt, 0);
    chk("t4_w0_busy", m_busy, 0);

    // 5: power down mid-high while measuring
    m_win = 16'd200;
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    wait_sd(1'b0, n);
    wait_sd(1'b1, n);
    tick();
    pd = 1'b1;
    tick();
    chk("t5_sd", sd_clk, 0);
    chk("t5_fall0", fall, 0);
    chk("t5_rise0", rise, 0);
    chk("t5_mbusy", m_busy, 0);
    chk("t5_mdone", m_done, 0);
    seen = 0;
    repeat (250) begin
      tick();
      if (m_done !== 1'b0 || sd_clk !== 1'b0)
        seen = 1;
    end
    chk("t5_quiet", seen, 0);
    pd = 1'b0;
    wait_sd(1'b1, n);
    chk("t5_restart", n, 7);

    // 6: async reset mid-RUN with a pending load
    div_in = 16'd9;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("t6_pend", div_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6");
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_sd", sd_clk, 0);
    chk("t6_post_adiv", act_div, 124);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
